// File: rtl/obstacle_pkg.sv
// Shared screen/obstacle constants and the speed-scaled step helper
// for the obstacle field controller.
package obstacle_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int OBS_W    = 32;
    localparam int OBS_H    = 32;
    localparam int STEP     = 4;

    // Effective fall distance per tick; callers cast down to their own width.
    function automatic logic [31:0] calc_step_eff(input logic [31:0] step,
                                                  input logic [1:0]  speed);
        return step << speed;
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: active flag plus x/y position, with spawn load,
// per-tick advance and a combinational retire strobe.
module obstacle_slot #(
    parameter int POS_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [POS_W-1:0] load_x,
    input  logic             advance,
    input  logic [POS_W+2:0] step_eff,
    input  logic [POS_W+2:0] limit,
    output logic             active,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             retire
);

    logic [POS_W+2:0] y_next;
    logic             over;

    // Sum kept 3 bits wider so a large step can never wrap below the limit.
    assign y_next = {3'b000, y} + step_eff;
    assign over   = (y_next > limit);
    assign retire = advance & active & over;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else if (clr) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else if (load) begin
            active <= 1'b1;
            x      <= load_x;
            y      <= '0;
        end else if (advance && active) begin
            // A retiring slot keeps its last position for the renderer.
            if (over) active <= 1'b0;
            else      y      <= y_next[POS_W-1:0];
        end
    end

endmodule

// File: rtl/obstacle_field_ctrl.sv
// Multi-slot obstacle controller: lowest-free-slot spawn, frame-tick fall,
// bottom-edge retirement with exit pulse/count and a live-slot count.
module obstacle_field_ctrl #(
    parameter int NUM_OBS  = 4,
    parameter int POS_W    = 10,
    parameter int SCREEN_H = obstacle_pkg::SCREEN_H,
    parameter int OBS_H    = obstacle_pkg::OBS_H,
    parameter int STEP     = obstacle_pkg::STEP,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     pause,
    input  logic                     clear,
    input  logic [1:0]               speed,
    input  logic                     spawn_valid,
    input  logic [POS_W-1:0]         spawn_x,
    output logic                     spawn_ready,
    output logic [NUM_OBS-1:0]       obs_active,
    output logic [NUM_OBS*POS_W-1:0] obs_x,
    output logic [NUM_OBS*POS_W-1:0] obs_y,
    output logic                     exit_pulse,
    output logic [CNT_W-1:0]         exit_count,
    output logic [4:0]               live_count
);

    import obstacle_pkg::*;

    localparam int EW = POS_W + 3;
    localparam logic [EW-1:0] LIMIT = EW'(SCREEN_H - OBS_H);

    logic [EW-1:0]      step_eff;
    logic [NUM_OBS-1:0] free_onehot;
    logic               free_found;
    logic               accept;
    logic               advance;
    logic [NUM_OBS-1:0] load;
    logic [NUM_OBS-1:0] retire;
    logic [NUM_OBS-1:0] next_active;
    logic [4:0]         next_live;
    logic [CNT_W-1:0]   retire_cnt;

    assign step_eff    = EW'(calc_step_eff(32'(STEP), speed));
    assign spawn_ready = ~&obs_active;
    assign accept      = spawn_valid & spawn_ready & ~clear;
    assign advance     = tick & ~pause & ~clear;
    assign load        = accept ? free_onehot : '0;

    // Lowest-index inactive slot wins.
    always_comb begin
        free_onehot = '0;
        free_found  = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!obs_active[i] && !free_found) begin
                free_onehot[i] = 1'b1;
                free_found     = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OBS; g++) begin : g_slot
            obstacle_slot #(.POS_W(POS_W)) u_slot (
                .clk      (clk),
                .reset    (reset),
                .clr      (clear),
                .load     (load[g]),
                .load_x   (spawn_x),
                .advance  (advance),
                .step_eff (step_eff),
                .limit    (LIMIT),
                .active   (obs_active[g]),
                .x        (obs_x[g*POS_W +: POS_W]),
                .y        (obs_y[g*POS_W +: POS_W]),
                .retire   (retire[g])
            );
        end
    endgenerate

    // Mirror of the slot flag update so live_count lands on the same edge.
    always_comb begin
        next_active = '0;
        next_live   = '0;
        retire_cnt  = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (clear)          next_active[i] = 1'b0;
            else if (load[i])   next_active[i] = 1'b1;
            else if (retire[i]) next_active[i] = 1'b0;
            else                next_active[i] = obs_active[i];
            if (next_active[i]) next_live  = next_live + 5'd1;
            if (retire[i])      retire_cnt = retire_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exit_pulse <= 1'b0;
            exit_count <= '0;
            live_count <= '0;
        end else begin
            exit_pulse <= |retire;
            exit_count <= exit_count + retire_cnt;
            live_count <= next_live;
        end
    end

endmodule

// File: tb/tb_obstacle_field_ctrl.sv
// Directed bench for obstacle_field_ctrl: reset, fill, bottom boundary,
// multi-retire, speed/pause and clear scenarios with hand-computed values.
module tb_obstacle_field_ctrl;

    localparam int NUM_OBS = 4;
    localparam int POS_W   = 10;
    localparam int CNT_W   = 16;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     tick = 1'b0;
    logic                     pause = 1'b0;
    logic                     clear = 1'b0;
    logic [1:0]               speed = 2'd0;
    logic                     spawn_valid = 1'b0;
    logic [POS_W-1:0]         spawn_x = '0;
    logic                     spawn_ready;
    logic [NUM_OBS-1:0]       obs_active;
    logic [NUM_OBS*POS_W-1:0] obs_x;
    logic [NUM_OBS*POS_W-1:0] obs_y;
    logic                     exit_pulse;
    logic [CNT_W-1:0]         exit_count;
    logic [4:0]               live_count;

    int total = 0;
    int bad   = 0;

    obstacle_field_ctrl #(
        .NUM_OBS(NUM_OBS), .POS_W(POS_W), .SCREEN_H(480), .OBS_H(32), .STEP(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .clear(clear),
        .speed(speed), .spawn_valid(spawn_valid), .spawn_x(spawn_x),
        .spawn_ready(spawn_ready), .obs_active(obs_active), .obs_x(obs_x),
        .obs_y(obs_y), .exit_pulse(exit_pulse), .exit_count(exit_count),
        .live_count(live_count)
    );

    always #5 clk = ~clk;

    function automatic logic [POS_W-1:0] gx(input int i);
        return obs_x[i*POS_W +: POS_W];
    endfunction

    function automatic logic [POS_W-1:0] gy(input int i);
        return obs_y[i*POS_W +: POS_W];
    endfunction

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic drive(input logic t, input logic p, input logic c, input logic [1:0] s,
                         input logic sv, input logic [POS_W-1:0] sx);
        tick = t; pause = p; clear = c; speed = s; spawn_valid = sv; spawn_x = sx;
        @(posedge clk);
        #1;
        tick = 1'b0; pause = 1'b0; clear = 1'b0; spawn_valid = 1'b0;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total++; if (obs_active !== 4'b0000) begin bad++; $display("FAIL reset_active got %b want 0000", obs_active); end
        total++; if (obs_x !== '0) begin bad++; $display("FAIL reset_x got %h want 0", obs_x); end
        total++; if (obs_y !== '0) begin bad++; $display("FAIL reset_y got %h want 0", obs_y); end
        total++; if (exit_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got %b want 0", exit_pulse); end
        total++; if (exit_count !== 16'd0) begin bad++; $display("FAIL reset_exit_count got %0d want 0", exit_count); end
        total++; if (live_count !== 5'd0) begin bad++; $display("FAIL reset_live got %0d want 0", live_count); end
        total++; if (spawn_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", spawn_ready); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_fill();
        apply_reset();
        drive(0, 0, 0, 2'd0, 1, 10'd100);
        total++; if (obs_active !== 4'b0001) begin bad++; $display("FAIL fill_latency got %b want 0001", obs_active); end
        drive(0, 0, 0, 2'd0, 1, 10'd200);
        drive(0, 0, 0, 2'd0, 1, 10'd300);
        drive(0, 0, 0, 2'd0, 1, 10'd400);
        total++; if (obs_active !== 4'b1111) begin bad++; $display("FAIL fill_active got %b want 1111", obs_active); end
        total++; if (gx(0) !== 10'd100) begin bad++; $display("FAIL fill_x0 got %0d want 100", gx(0)); end
        total++; if (gx(1) !== 10'd200) begin bad++; $display("FAIL fill_x1 got %0d want 200", gx(1)); end
        total++; if (gx(2) !== 10'd300) begin bad++; $display("FAIL fill_x2 got %0d want 300", gx(2)); end
        total++; if (gx(3) !== 10'd400) begin bad++; $display("FAIL fill_x3 got %0d want 400", gx(3)); end
        total++; if (obs_y !== '0) begin bad++; $display("FAIL fill_y got %h want 0", obs_y); end
        total++; if (live_count !== 5'd4) begin bad++; $display("FAIL fill_live got %0d want 4", live_count); end
        total++; if (spawn_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got %b want 0", spawn_ready); end
        drive(0, 0, 0, 2'd0, 1, 10'd500);
        total++; if (obs_x !== {10'd400, 10'd300, 10'd200, 10'd100}) begin bad++; $display("FAIL fill_fifth_x got %h want unchanged", obs_x); end
        total++; if (live_count !== 5'd4) begin bad++; $display("FAIL fill_fifth_live got %0d want 4", live_count); end
    endtask

    task automatic test_boundary();
        apply_reset();
        drive(0, 0, 0, 2'd0, 1, 10'd50);
        for (int i = 0; i < 111; i++) drive(1, 0, 0, 2'd0, 0, 10'd0);
        total++; if (gy(0) !== 10'd444) begin bad++; $display("FAIL bnd_y444 got %0d want 444", gy(0)); end
        drive(1, 0, 0, 2'd0, 0, 10'd0);
        total++; if (gy(0) !== 10'd448) begin bad++; $display("FAIL bnd_y448 got %0d want 448", gy(0)); end
        total++; if (obs_active !== 4'b0001) begin bad++; $display("FAIL bnd_at_limit_active got %b want 0001", obs_active); end
        total++; if (exit_pulse !== 1'b0) begin bad++; $display("FAIL bnd_no_pulse got %b want 0", exit_pulse); end
        drive(1, 0, 0, 2'd0, 0, 10'd0);
        total++; if (obs_active !== 4'b0000) begin bad++; $display("FAIL bnd_retire_active got %b want 0000", obs_active); end
        total++; if (gy(0) !== 10'd448) begin bad++; $display("FAIL bnd_hold_y got %0d want 448", gy(0)); end
        total++; if (exit_pulse !== 1'b1) begin bad++; $display("FAIL bnd_pulse got %b want 1", exit_pulse); end
        total++; if (exit_count !== 16'd1) begin bad++; $display("FAIL bnd_count got %0d want 1", exit_count); end
        total++; if (live_count !== 5'd0) begin bad++; $display("FAIL bnd_live got %0d want 0", live_count); end
        drive(0, 0, 0, 2'd0, 0, 10'd0);
        total++; if (exit_pulse !== 1'b0) begin bad++; $display("FAIL bnd_pulse_one_cycle got %b want 0", exit_pulse); end
        total++; if (exit_count !== 16'd1) begin bad++; $display("FAIL bnd_count_hold got %0d want 1", exit_count); end
    endtask

    task automatic test_multi_retire();
        apply_reset();
        drive(0, 0, 0, 2'd0, 1, 10'd10);
        for (int i = 0; i < 14; i++) drive(1, 0, 0, 2'd3, 0, 10'd0);
        total++; if (gy(0) !== 10'd448) begin bad++; $display("FAIL mr_fast_y got %0d want 448", gy(0)); end
        drive(0, 0, 0, 2'd0, 1, 10'd111);
        drive(0, 0, 0, 2'd0, 1, 10'd222);
        drive(1, 0, 0, 2'd0, 0, 10'd0);
        total++; if (obs_active !== 4'b0110 || exit_count !== 16'd1) begin bad++; $display("FAIL mr_first_retire got act=%b cnt=%0d want act=0110 cnt=1", obs_active, exit_count); end
        for (int i = 0; i < 111; i++) drive(1, 0, 0, 2'd0, 0, 10'd0);
        drive(0, 0, 0, 2'd0, 1, 10'd55);
        drive(0, 0, 0, 2'd0, 1, 10'd66);
        total++; if (obs_active !== 4'b1111 || gy(1) !== 10'd448 || gy(2) !== 10'd448) begin bad++; $display("FAIL mr_setup got act=%b y1=%0d y2=%0d want 1111/448/448", obs_active, gy(1), gy(2)); end
        drive(1, 0, 0, 2'd0, 1, 10'd999);
        total++; if (obs_active !== 4'b1001) begin bad++; $display("FAIL mr_active got %b want 1001", obs_active); end
        total++; if (exit_count !== 16'd3) begin bad++; $display("FAIL mr_count got %0d want 3", exit_count); end
        total++; if (exit_pulse !== 1'b1) begin bad++; $display("FAIL mr_pulse got %b want 1", exit_pulse); end
        total++; if (live_count !== 5'd2) begin bad++; $display("FAIL mr_live got %0d want 2", live_count); end
        total++; if (gy(0) !== 10'd4 || gy(3) !== 10'd4) begin bad++; $display("FAIL mr_move got y0=%0d y3=%0d want 4/4", gy(0), gy(3)); end
        total++; if (gx(2) !== 10'd222 || gy(2) !== 10'd448) begin bad++; $display("FAIL mr_hold got x2=%0d y2=%0d want 222/448", gx(2), gy(2)); end
        drive(0, 0, 0, 2'd0, 1, 10'd777);
        total++; if (obs_active !== 4'b1011) begin bad++; $display("FAIL mr_refill_active got %b want 1011", obs_active); end
        total++; if (gx(1) !== 10'd777 || gy(1) !== 10'd0) begin bad++; $display("FAIL mr_refill_pos got x1=%0d y1=%0d want 777/0", gx(1), gy(1)); end
        total++; if (exit_pulse !== 1'b0 || live_count !== 5'd3) begin bad++; $display("FAIL mr_after got pulse=%b live=%0d want 0/3", exit_pulse, live_count); end
    endtask

    task automatic test_speed_pause();
        apply_reset();
        drive(0, 0, 0, 2'd0, 1, 10'd5);
        drive(1, 0, 0, 2'd2, 0, 10'd0);
        total++; if (gy(0) !== 10'd16) begin bad++; $display("FAIL sp_speed2 got %0d want 16", gy(0)); end
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 2'd2, 0, 10'd0);
        total++; if (gy(0) !== 10'd16) begin bad++; $display("FAIL sp_pause_hold got %0d want 16", gy(0)); end
        drive(1, 1, 0, 2'd2, 1, 10'd6);
        total++; if (obs_active !== 4'b0011 || gx(1) !== 10'd6 || gy(1) !== 10'd0 || gy(0) !== 10'd16) begin bad++; $display("FAIL sp_pause_spawn got act=%b x1=%0d y1=%0d y0=%0d want 0011/6/0/16", obs_active, gx(1), gy(1), gy(0)); end
        drive(1, 0, 0, 2'd1, 1, 10'd7);
        total++; if (gy(0) !== 10'd24 || gy(1) !== 10'd8) begin bad++; $display("FAIL sp_speed1 got y0=%0d y1=%0d want 24/8", gy(0), gy(1)); end
        total++; if (obs_active !== 4'b0111 || gy(2) !== 10'd0 || gx(2) !== 10'd7) begin bad++; $display("FAIL sp_tick_spawn got act=%b y2=%0d x2=%0d want 0111/0/7", obs_active, gy(2), gx(2)); end
        total++; if (live_count !== 5'd3) begin bad++; $display("FAIL sp_live got %0d want 3", live_count); end
    endtask

    task automatic test_clear();
        apply_reset();
        drive(0, 0, 0, 2'd0, 1, 10'd9);
        for (int i = 0; i < 15; i++) drive(1, 0, 0, 2'd3, 0, 10'd0);
        drive(0, 0, 0, 2'd0, 1, 10'd11);
        for (int i = 0; i < 14; i++) drive(1, 0, 0, 2'd3, 0, 10'd0);
        drive(0, 0, 0, 2'd0, 1, 10'd20);
        drive(0, 0, 0, 2'd0, 1, 10'd30);
        total++; if (obs_active !== 4'b0111 || exit_count !== 16'd1 || gy(0) !== 10'd448) begin bad++; $display("FAIL clr_setup got act=%b cnt=%0d y0=%0d want 0111/1/448", obs_active, exit_count, gy(0)); end
        drive(1, 0, 1, 2'd0, 1, 10'd40);
        total++; if (obs_active !== 4'b0000) begin bad++; $display("FAIL clr_active got %b want 0000", obs_active); end
        total++; if (obs_x !== '0 || obs_y !== '0) begin bad++; $display("FAIL clr_pos got x=%h y=%h want 0/0", obs_x, obs_y); end
        total++; if (exit_count !== 16'd1) begin bad++; $display("FAIL clr_count got %0d want 1", exit_count); end
        total++; if (exit_pulse !== 1'b0) begin bad++; $display("FAIL clr_pulse got %b want 0", exit_pulse); end
        total++; if (live_count !== 5'd0 || spawn_ready !== 1'b1) begin bad++; $display("FAIL clr_live got live=%0d ready=%b want 0/1", live_count, spawn_ready); end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 2'd0, 1, 10'd123);
        drive(0, 0, 0, 2'd0, 1, 10'd321);
        #2 reset = 1'b1;
        #1;
        total++; if (obs_active !== 4'b0000 || obs_x !== '0 || live_count !== 5'd0 || exit_count !== 16'd0) begin bad++; $display("FAIL mid_reset got act=%b x=%h live=%0d cnt=%0d want all 0", obs_active, obs_x, live_count, exit_count); end
        @(posedge clk);
        #1 reset = 1'b0;
        drive(0, 0, 0, 2'd0, 0, 10'd0);
        total++; if (obs_active !== 4'b0000) begin bad++; $display("FAIL mid_reset_after got %b want 0000", obs_active); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_boundary();
        test_multi_retire();
        test_speed_pause();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obstacle_field_ctrl.md
Name: obstacle_field_ctrl

Overview:
- Parametrised multi-obstacle controller for the HDMI game.
- Manages NUM_OBS independent obstacle slots. Each slot has an active flag and x/y position.
- Slots are spawned by a valid/ready request, fall by a speed-scaled step on each frame tick, and retire when they pass the bottom of the screen.
- Sits between the game FSM / spawn generator and the sprite renderer and collision checker.

Parameters:
- NUM_OBS, 4, number of obstacle slots (1..16)
- POS_W, 10, width of x/y coordinates
- SCREEN_H, 480, visible screen height in pixels
- OBS_H, 32, obstacle height in pixels
- STEP, 4, base vertical step per tick
- CNT_W, 16, width of the exit counter

Ports:
- clk  in  1  pixel/game clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  frame tick, one-cycle pulse, advances all active obstacles
- pause  in  1  when high, tick is ignored
- clear  in  1  synchronous clear of all slots
- speed  in  2  step multiplier select: step_eff = STEP << speed
- spawn_valid  in  1  spawn request
- spawn_x  in  POS_W  x position for the spawned obstacle
- spawn_ready  out  1  a free slot exists
- obs_active  out  NUM_OBS  per-slot active flag
- obs_x  out  NUM_OBS*POS_W  flattened x positions, slot i at bits [i*POS_W +: POS_W]
- obs_y  out  NUM_OBS*POS_W  flattened y positions, same packing
- exit_pulse  out  1  one-cycle pulse when one or more obstacles retire
- exit_count  out  CNT_W  total retired obstacles, wraps modulo 2^CNT_W
- live_count  out  5  number of active slots

Behaviour:
- Reset (asynchronous, reset high) clears everything:
  - obs_active = 0, all obs_x = 0, all obs_y = 0
  - exit_pulse = 0, exit_count = 0, live_count = 0
- Constants:
  - LIMIT = SCREEN_H - OBS_H (default 448)
  - step_eff = STEP << speed, computed at POS_W+3 bits
- spawn_ready is combinational: spawn_ready = ~&obs_active, taken from the registered flags.
- Spawn accept (spawn_valid & spawn_ready & ~clear):
  - the lowest-index inactive slot k is chosen
  - next edge: active[k]=1, x[k]=spawn_x, y[k]=0
  - one spawn per cycle; latency 1 cycle to obs_active
- Tick processing (tick & ~pause & ~clear), applied to every slot that was active before this edge:
  - y+step_eff is compared in POS_W+3 bits; no wrap-around is allowed
  - if y+step_eff > LIMIT: active=0, and x/y hold their last values
  - else: y = y+step_eff
- Exit accounting:
  - exit_pulse = 1 for exactly the cycle after any slot retires
  - exit_count += number of slots retired on that edge, which can be more than one
- Simultaneous spawn and tick:
  - the newly spawned slot is not moved this edge and starts at y=0
  - a slot freed by this tick is not spawnable until the next cycle, because spawn_ready uses the pre-edge flags
- clear:
  - all active=0 and positions=0 on the next edge
  - spawn and tick are ignored that cycle
  - exit_count is unchanged and no exit_pulse is generated
- pause:
  - freezes motion only; spawns are still accepted
- speed:
  - sampled on the tick cycle; changes take effect on the next tick
- live_count:
  - registered popcount of obs_active
  - updated in the same edge as the flags, so it is always consistent with obs_active
- Reset mid-operation: asynchronous clear to the reset values above; no pending request survives.

Decomposition:
- Package obstacle_pkg holds:
  - default constants: SCREEN_W=640, SCREEN_H=480, OBS_W/OBS_H=32, STEP=4
  - a function for step_eff
- Sub-module obstacle_slot, instantiated NUM_OBS times:
  - holds active/x/y for one slot
  - inputs: load, load_x, advance, step_eff, limit, clr
  - outputs: the slot's active/x/y and a retire strobe
- Top level holds the free-slot priority encoder, the popcount and the exit counter.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> all outputs are 0 immediately, and spawn_ready=1.
- Fill the slots: spawn_valid with spawn_x=100,200,300,400 on 4 consecutive cycles -> slots 0..3 active with those x values, y=0; live_count=4; spawn_ready=0; a 5th request is not accepted.
- Bottom boundary: slot at y=444, speed=0, one tick -> y=448 and still active; next tick -> 452>448, so active=0, exit_pulse high for one cycle, exit_count increments by 1.
- Multi-retire plus spawn in the same cycle: with all 4 slots active, slots 1 and 2 at y=448, then tick together with spawn_valid -> both retire, exit_count += 2, spawn is not accepted that cycle; the next cycle's spawn fills slot 1.
- Speed and pause: speed=2, tick at y=0 -> y=16; then pause=1 with 3 ticks -> y stays 16; a spawn during the pause is still accepted.
- Clear: with 3 slots active, pulse clear together with tick and spawn_valid -> all slots inactive, positions 0, exit_count unchanged, exit_pulse=0.
